// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a byte FIFO with one-cycle read latency and packs
// BYTES_PER_WORD bytes per output word, first byte in the LSBs. Words leave
// on a valid/ready port; flush pushes out a zero-padded partial word.
//
// Handshake: out_valid rises with a word and stays high, with out_data and
// out_keep held, until the cycle where out_valid & out_ready are both high.
// That cycle is the transfer. A new word may load in the same cycle.
module fifo_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               flush,
  input  logic                               fifo_empty,
  input  logic [DATA_WIDTH-1:0]              fifo_data,
  input  logic                               fifo_data_valid,
  output logic                               fifo_request,
  output logic                               fifo_read_req,
  output logic [BYTES_PER_WORD*DATA_WIDTH-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]          out_keep,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CNT_WIDTH-1:0]               words_sent,
  output logic                               busy,
  output logic                               err_underflow,
  output logic [1:0]                         dbg_state_o
);

  localparam int N   = BYTES_PER_WORD;
  localparam int WW  = N * DATA_WIDTH;
  localparam int BCW = $clog2(N + 1);
  localparam logic [BCW-1:0] N_CNT = BCW'(N);
  localparam logic [BCW:0]   N_EXT = (BCW + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STOP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                 rd_pending_q;
  logic [WW-1:0]        pack_q, pack_d;
  logic [WW-1:0]        out_data_q, out_data_d;
  logic [N-1:0]         out_keep_q, out_keep_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] words_sent_q, words_sent_d;
  logic                 err_q, err_d;

  logic                 has_bytes;
  logic                 xfer;
  logic                 rd_req;
  logic [BCW-1:0]       cnt_base;
  logic [BCW:0]         inflight;

  // Transfer and read-issue decisions; a read is only issued if the lane it
  // will land in is free once any in-flight byte has been captured.
  always_comb begin
    has_bytes = (byte_cnt_q != '0);
    xfer      = ((byte_cnt_q == N_CNT) ||
                 (state_q == S_FLUSH && !rd_pending_q && has_bytes)) &&
                (!out_valid_q || out_ready);
    cnt_base  = xfer ? '0 : byte_cnt_q;
    inflight  = {1'b0, cnt_base} + {{BCW{1'b0}}, rd_pending_q};
    rd_req    = (state_q == S_RUN) && enable && !flush && !fifo_empty &&
                (inflight < N_EXT);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush wins over a dropped enable in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable)                 state_d = S_RUN;
        else if (flush && has_bytes) state_d = S_FLUSH;
      end
      S_RUN: begin
        if (flush)        state_d = (has_bytes || rd_pending_q) ? S_FLUSH : S_IDLE;
        else if (!enable) state_d = S_STOP;
      end
      S_STOP: begin
        if (!rd_pending_q) state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (!rd_pending_q && (!has_bytes || xfer)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-derived outputs; Request stays high while a byte is in flight.
  always_comb begin
    busy          = (state_q != S_IDLE);
    fifo_request  = (state_q != S_IDLE) || rd_pending_q;
    fifo_read_req = rd_req;
    dbg_state_o   = state_q;
  end

  // Pack register, byte count and output word next-state values.
  always_comb begin
    pack_d       = xfer ? '0 : pack_q;
    byte_cnt_d   = cnt_base;
    err_d        = err_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    words_sent_d = words_sent_q;
    if (rd_pending_q) begin
      if (fifo_data_valid) begin
        for (int i = 0; i < N; i++) begin
          if (BCW'(i) == cnt_base) pack_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
        end
        byte_cnt_d = cnt_base + BCW'(1);
      end else begin
        err_d = 1'b1;
      end
    end
    if (xfer) begin
      out_data_d  = pack_q;
      out_valid_d = 1'b1;
      for (int i = 0; i < N; i++) begin
        out_keep_d[i] = (BCW'(i) < byte_cnt_q);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) words_sent_d = words_sent_q + CNT_WIDTH'(1);
  end

  // Datapath registers; reset discards partial bytes and any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      pack_q       <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      words_sent_q <= '0;
      err_q        <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      rd_pending_q <= rd_req;
      pack_q       <= pack_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      words_sent_q <= words_sent_d;
      err_q        <= err_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_keep      = out_keep_q;
  assign out_valid     = out_valid_q;
  assign words_sent    = words_sent_q;
  assign err_underflow = err_q;

endmodule
